// File: rtl/alarm_ctrl.sv
// Alarm clock controller: stored alarm time, IDLE/RINGING/SNOOZE sequencing
// with bounded ring and snooze durations, and validated alarm loading.
module alarm_ctrl #(
  parameter int unsigned SNOOZE_SEC = 540,
  parameter int unsigned RING_SEC   = 300
) (
  input  logic       clk_1hz,
  input  logic       reset_n,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic       alarm_en,
  input  logic       set_alarm,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic       snooze,
  input  logic       stop,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic       ringing,
  output logic       snoozed,
  output logic       set_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_e;

  localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_SEC - 1);
  localparam logic [11:0] RING_LAST   = 12'(RING_SEC - 1);

  state_e      state_q, state_d;
  logic [11:0] ring_cnt_q, ring_cnt_d;
  logic [11:0] snz_cnt_q, snz_cnt_d;
  logic [4:0]  alarm_hours_q, alarm_hours_d;
  logic [5:0]  alarm_minutes_q, alarm_minutes_d;
  logic        ringing_q, ringing_d;
  logic        snoozed_q, snoozed_d;
  logic        set_err_q, set_err_d;
  logic        match_s;
  logic        set_ok_s;

  // Match uses the currently stored alarm, so a same-edge load only affects later edges.
  assign match_s  = alarm_en && (hours == alarm_hours_q) && (minutes == alarm_minutes_q)
                    && (seconds == 6'd0);
  assign set_ok_s = (set_hours <= 5'd23) && (set_minutes <= 6'd59);

  // Next-state, counter and alarm-register logic.
  always_comb begin
    state_d         = state_q;
    ring_cnt_d      = ring_cnt_q;
    snz_cnt_d       = snz_cnt_q;
    alarm_hours_d   = alarm_hours_q;
    alarm_minutes_d = alarm_minutes_q;
    set_err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (match_s) begin
          state_d    = RINGING;
          ring_cnt_d = 12'd0;
        end else begin
          state_d = IDLE;
        end
      end
      RINGING: begin
        if (!alarm_en) begin
          state_d = IDLE;
        end else if (stop) begin
          state_d = IDLE;
        end else if (snooze) begin
          state_d   = SNOOZE;
          snz_cnt_d = SNOOZE_LOAD;
        end else if (ring_cnt_q == RING_LAST) begin
          state_d = IDLE;
        end else begin
          ring_cnt_d = ring_cnt_q + 12'd1;
        end
      end
      SNOOZE: begin
        if (!alarm_en) begin
          state_d = IDLE;
        end else if (stop) begin
          state_d = IDLE;
        end else if (snz_cnt_q == 12'd0) begin
          state_d    = RINGING;
          ring_cnt_d = 12'd0;
        end else begin
          snz_cnt_d = snz_cnt_q - 12'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (set_alarm) begin
      if (set_ok_s) begin
        alarm_hours_d   = set_hours;
        alarm_minutes_d = set_minutes;
        set_err_d       = 1'b0;
      end else begin
        set_err_d = 1'b1;
      end
    end else begin
      set_err_d = 1'b0;
    end

    ringing_d = (state_d == RINGING);
    snoozed_d = (state_d == SNOOZE);
  end

  // State and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clk_1hz or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      ring_cnt_q      <= 12'd0;
      snz_cnt_q       <= 12'd0;
      alarm_hours_q   <= 5'd0;
      alarm_minutes_q <= 6'd0;
      ringing_q       <= 1'b0;
      snoozed_q       <= 1'b0;
      set_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      ring_cnt_q      <= ring_cnt_d;
      snz_cnt_q       <= snz_cnt_d;
      alarm_hours_q   <= alarm_hours_d;
      alarm_minutes_q <= alarm_minutes_d;
      ringing_q       <= ringing_d;
      snoozed_q       <= snoozed_d;
      set_err_q       <= set_err_d;
    end
  end

  assign alarm_hours   = alarm_hours_q;
  assign alarm_minutes = alarm_minutes_q;
  assign ringing       = ringing_q;
  assign snoozed       = snoozed_q;
  assign set_err       = set_err_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_alarm_ctrl;

  logic       clk_1hz;
  logic       reset_n;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       alarm_en;
  logic       set_alarm;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic       snooze;
  logic       stop;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       ringing;
  logic       snoozed;
  logic       set_err;

  alarm_ctrl #(.SNOOZE_SEC(540), .RING_SEC(300)) dut (
    .clk_1hz      (clk_1hz),
    .reset_n      (reset_n),
    .seconds      (seconds),
    .minutes      (minutes),
    .hours        (hours),
    .alarm_en     (alarm_en),
    .set_alarm    (set_alarm),
    .set_hours    (set_hours),
    .set_minutes  (set_minutes),
    .snooze       (snooze),
    .stop         (stop),
    .alarm_hours  (alarm_hours),
    .alarm_minutes(alarm_minutes),
    .ringing      (ringing),
    .snoozed      (snoozed),
    .set_err      (set_err)
  );

  initial begin
    clk_1hz = 1'b0;
    forever #5 clk_1hz = ~clk_1hz;
  end

  // Expected vector layout: {ringing, snoozed, set_err, alarm_hours, alarm_minutes}
  logic [13:0] sb_q[$];
  int          id_q[$];
  int          step_id;
  int          n_checks;
  int          n_pass;
  logic [4:0]  exp_ah;
  logic [5:0]  exp_am;

  // Monitor: one expected entry per negedge when the scoreboard holds one.
  always @(negedge clk_1hz) begin
    logic [13:0] exp_v;
    logic [13:0] obs_v;
    int          id;
    obs_v = {ringing, snoozed, set_err, alarm_hours, alarm_minutes};
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      id    = id_q.pop_front();
      n_checks++;
      if (obs_v === exp_v) begin
        n_pass++;
      end else begin
        $display("FAIL step%0d outputs: got ring=%b snz=%b err=%b alarm=%0d:%0d, want ring=%b snz=%b err=%b alarm=%0d:%0d",
                 id, obs_v[13], obs_v[12], obs_v[11], obs_v[10:6], obs_v[5:0],
                 exp_v[13], exp_v[12], exp_v[11], exp_v[10:6], exp_v[5:0]);
      end
      n_checks++;
      if (!(ringing === 1'b1 && snoozed === 1'b1)) begin
        n_pass++;
      end else begin
        $display("FAIL step%0d exclusive: got ringing=%b snoozed=%b, want not both high",
                 id, ringing, snoozed);
      end
    end
  end

  task automatic push_exp(input logic r, input logic s, input logic e);
    sb_q.push_back({r, s, e, exp_ah, exp_am});
    id_q.push_back(step_id);
    step_id++;
  endtask

  // One clock edge with the inputs currently applied; expectation is for after the edge.
  task automatic cyc(input logic r, input logic s, input logic e);
    @(posedge clk_1hz);
    push_exp(r, s, e);
    #2;
  endtask

  task automatic ncyc(input int n, input logic r, input logic s, input logic e);
    for (int i = 0; i < n; i++) cyc(r, s, e);
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    hours   = h;
    minutes = m;
    seconds = s;
  endtask

  // Mid-cycle async reset: expectation is checked at the following negedge with no posedge between.
  task automatic pulse_reset();
    @(posedge clk_1hz);
    #2;
    reset_n = 1'b0;
    exp_ah  = 5'd0;
    exp_am  = 6'd0;
    push_exp(1'b0, 1'b0, 1'b0);
    @(negedge clk_1hz);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    step_id     = 0;
    n_checks    = 0;
    n_pass      = 0;
    reset_n     = 1'b0;
    set_time(5'd12, 6'd0, 6'd1);
    alarm_en    = 1'b0;
    set_alarm   = 1'b0;
    set_hours   = 5'd0;
    set_minutes = 6'd0;
    snooze      = 1'b0;
    stop        = 1'b0;
    exp_ah      = 5'd0;
    exp_am      = 6'd0;
    push_exp(1'b0, 1'b0, 1'b0);
    @(negedge clk_1hz);
    #2;
    reset_n = 1'b1;

    // Load 06:30 while time is 06:29:59; old alarm 00:00 cannot match.
    set_time(5'd6, 6'd29, 6'd59);
    alarm_en = 1'b1; set_alarm = 1'b1; set_hours = 5'd6; set_minutes = 6'd30;
    exp_ah = 5'd6; exp_am = 6'd30;
    cyc(1'b0, 1'b0, 1'b0);
    set_alarm = 1'b0;
    set_time(5'd6, 6'd30, 6'd0);
    cyc(1'b1, 1'b0, 1'b0);

    // Snooze lasts 540 cycles, then rings again; stop returns to idle.
    set_time(5'd6, 6'd30, 6'd1);
    snooze = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    snooze = 1'b0;
    ncyc(539, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    stop = 1'b0;

    // Unattended ring lasts exactly 300 cycles.
    set_time(5'd6, 6'd29, 6'd59);
    cyc(1'b0, 1'b0, 1'b0);
    set_time(5'd6, 6'd30, 6'd0);
    cyc(1'b1, 1'b0, 1'b0);
    set_time(5'd6, 6'd30, 6'd1);
    ncyc(299, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    set_time(5'd6, 6'd30, 6'd0);
    cyc(1'b1, 1'b0, 1'b0);

    // Snooze and stop together while ringing: stop wins.
    set_time(5'd6, 6'd30, 6'd1);
    snooze = 1'b1; stop = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    // Snooze and stop in idle are ignored.
    stop = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    snooze = 1'b0;

    // Rejected loads: hours 24, then minutes 60.
    set_alarm = 1'b1; set_hours = 5'd24; set_minutes = 6'd10;
    cyc(1'b0, 1'b0, 1'b1);
    set_alarm = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    set_alarm = 1'b1; set_hours = 5'd6; set_minutes = 6'd60;
    cyc(1'b0, 1'b0, 1'b1);
    set_alarm = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // alarm_en dropped in snooze, then in ringing.
    set_time(5'd6, 6'd30, 6'd0);
    cyc(1'b1, 1'b0, 1'b0);
    set_time(5'd6, 6'd30, 6'd1);
    snooze = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    snooze = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    alarm_en = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    set_time(5'd6, 6'd30, 6'd0);
    cyc(1'b0, 1'b0, 1'b0);
    alarm_en = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    set_time(5'd6, 6'd30, 6'd1);
    alarm_en = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    alarm_en = 1'b1;

    // Load and match on the same edge: old alarm 06:30 matches, 07:00 takes over.
    set_time(5'd6, 6'd30, 6'd0);
    set_alarm = 1'b1; set_hours = 5'd7; set_minutes = 6'd0;
    exp_ah = 5'd7; exp_am = 6'd0;
    cyc(1'b1, 1'b0, 1'b0);
    // Valid load while ringing leaves the ring running.
    set_time(5'd6, 6'd30, 6'd1);
    set_hours = 5'd6; set_minutes = 6'd30;
    exp_ah = 5'd6; exp_am = 6'd30;
    cyc(1'b1, 1'b0, 1'b0);
    set_alarm = 1'b0;
    stop = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    stop = 1'b0;

    // Async reset mid-snooze; only a fresh match at 00:00:00 rings afterwards.
    set_time(5'd6, 6'd30, 6'd0);
    cyc(1'b1, 1'b0, 1'b0);
    set_time(5'd6, 6'd30, 6'd1);
    snooze = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    snooze = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    pulse_reset();
    cyc(1'b0, 1'b0, 1'b0);
    set_time(5'd0, 6'd0, 6'd0);
    cyc(1'b1, 1'b0, 1'b0);
    set_time(5'd0, 6'd0, 6'd1);
    stop = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    stop = 1'b0;

    @(negedge clk_1hz);
    #1;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 The block SHALL provide parameter SNOOZE_SEC, default 540, meaning snooze duration in seconds (legal range 1..4095).
REQ-002 The block SHALL provide parameter RING_SEC, default 300, meaning maximum ring duration in seconds before auto-stop (legal range 1..4095).
REQ-003 clk_1hz  in  1  one-second timebase; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 seconds  in  6  current time seconds, 0..59, from the time counter.
REQ-006 minutes  in  6  current time minutes, 0..59.
REQ-007 hours  in  5  current time hours, 0..23.
REQ-008 alarm_en  in  1  level; 1 = alarm armed.
REQ-009 set_alarm  in  1  sampled strobe; load set_hours/set_minutes as the alarm time.
REQ-010 set_hours  in  5  alarm hours to load.
REQ-011 set_minutes  in  6  alarm minutes to load.
REQ-012 snooze  in  1  sampled request to snooze.
REQ-013 stop  in  1  sampled request to silence the alarm.
REQ-014 alarm_hours  out  5  stored alarm hours.
REQ-015 alarm_minutes  out  6  stored alarm minutes.
REQ-016 ringing  out  1  registered; 1 while state = RINGING.
REQ-017 snoozed  out  1  registered; 1 while state = SNOOZE.
REQ-018 set_err  out  1  registered one-cycle pulse on a rejected set_alarm.

Function
REQ-019 The block SHALL implement states IDLE, RINGING and SNOOZE, held in a registered state variable.
REQ-020 The block SHALL define match as: alarm_en=1, hours=alarm_hours, minutes=alarm_minutes and seconds=0, evaluated on current inputs.
REQ-021 In IDLE, a sampled match SHALL move the FSM to RINGING, clear the ring counter, and assert ringing in the cycle after that edge; stop and snooze SHALL be ignored in IDLE.
REQ-022 In RINGING, priority SHALL be: alarm_en=0 -> IDLE; else stop=1 -> IDLE; else snooze=1 -> SNOOZE with the snooze counter loaded to SNOOZE_SEC-1; else ring counter = RING_SEC-1 -> IDLE; else the ring counter increments by 1.
REQ-023 In SNOOZE, priority SHALL be: alarm_en=0 -> IDLE; else stop=1 -> IDLE; else snooze counter = 0 -> RINGING with the ring counter cleared; else the snooze counter decrements by 1.
REQ-024 Match SHALL be ignored while in RINGING or SNOOZE; re-snoozing after a snooze-to-RINGING re-entry SHALL be permitted without limit.
REQ-025 Ring and snooze counters SHALL be 12 bits wide, unsigned, and SHALL never wrap.
REQ-026 set_alarm with set_hours<=23 and set_minutes<=59 SHALL update alarm_hours/alarm_minutes at that edge; FSM state and counters SHALL be unaffected.
REQ-027 set_alarm with set_hours>23 or set_minutes>59 SHALL leave the stored alarm unchanged and pulse set_err high for exactly one cycle.
REQ-028 set_alarm and match on the same edge SHALL compare against the old stored alarm; the new value takes effect from the next edge.
REQ-029 ringing and snoozed SHALL never be high simultaneously.

Reset
REQ-030 reset_n=0 SHALL immediately, without a clock edge, force state=IDLE, ringing=0, snoozed=0, set_err=0, alarm_hours=0, alarm_minutes=0, and both counters to 0.
REQ-031 Reset asserted mid-ring or mid-snooze SHALL abandon the operation; after release the FSM SHALL resume from IDLE, and only a fresh match SHALL ring.

Verification
REQ-032 Load 06:30, alarm_en=1, drive time 06:29:59 -> 06:30:00 -> ringing=1 one cycle after the 06:30:00 edge; snoozed=0.
REQ-033 Ringing, snooze=1 for one cycle with SNOOZE_SEC=540 -> snoozed=1 for 540 cycles, then ringing=1 again; stop=1 at the next edge -> IDLE.
REQ-034 Ringing with no input and RING_SEC=300 -> ringing stays high for exactly 300 cycles, then IDLE; a repeated 06:30:00 the next day rings again.
REQ-035 set_alarm with set_hours=24 and set_minutes=10 -> set_err pulses for 1 cycle, alarm stays 06:30; set_minutes=60 -> same result.
REQ-036 Snooze and stop asserted on the same edge while RINGING -> IDLE; alarm_en dropped in SNOOZE -> IDLE at the next edge.
REQ-037 reset_n pulsed low mid-SNOOZE -> outputs cleared asynchronously, alarm=00:00; time 00:00:00 with alarm_en=1 -> ringing=1.
